// File: rtl/bus_pkg.sv
// Shared widths, rw encodings and initiator state type for the daisy-chain bus.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 16;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } init_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Clear/enable counter that saturates at Terminal and flags reaching it.
module bus_timeout_counter #(
  parameter int unsigned Width    = 11,
  parameter int unsigned Terminal = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == Width'(Terminal));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_initiator.sv
// Host-side initiator for the 16-bit addr/data/rw/valid daisy-chain bus.
// Define BUS_INITIATOR_TIMEOUT_EN to abandon WAIT after TIMEOUT_CYCLES cycles.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [BUS_ADDR_W-1:0]  cmd_addr_i,
  input  logic [BUS_DATA_W-1:0]  cmd_data_i,
  input  logic                   cmd_rw_i,
  output logic [BUS_ADDR_W-1:0]  bus_addr_o,
  output logic [BUS_DATA_W-1:0]  bus_data_o,
  output logic                   bus_rw_o,
  output logic                   bus_valid_o,
  input  logic [BUS_ADDR_W-1:0]  bus_addr_i,
  input  logic [BUS_DATA_W-1:0]  bus_data_i,
  input  logic                   bus_rw_i,
  input  logic                   bus_valid_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [BUS_DATA_W-1:0]  resp_data_o,
  output logic                   resp_err_o,
  output logic                   stray_o,
  output logic [COUNT_WIDTH-1:0] txn_count_o
);

  init_state_e            state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic [BUS_ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [BUS_DATA_W-1:0]  bus_data_q, bus_data_d;
  logic                   bus_rw_q, bus_rw_d;
  logic                   bus_valid_q, bus_valid_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [BUS_DATA_W-1:0]  resp_data_q, resp_data_d;
  logic                   resp_err_q, resp_err_d;
  logic                   stray_q, stray_d;
  logic [COUNT_WIDTH-1:0] txn_count_q, txn_count_d;
  logic                   match;
  logic                   timeout;

  // bus_addr_q/bus_rw_q double as the latched command until the next issue.
  assign match = bus_valid_i && (bus_addr_i == bus_addr_q) && (bus_rw_i == bus_rw_q);

`ifdef BUS_INITIATOR_TIMEOUT_EN
  bus_timeout_counter #(
    .Width   ($clog2(TIMEOUT_CYCLES) + 1),
    .Terminal(TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q != StWait),
    .en_i (state_q == StWait),
    .tc_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    bus_addr_d   = bus_addr_q;
    bus_data_d   = bus_data_q;
    bus_rw_d     = bus_rw_q;
    bus_valid_d  = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    stray_d      = 1'b0;
    txn_count_d  = txn_count_q;
    unique case (state_q)
      StIdle: begin
        stray_d = bus_valid_i;
        if (cmd_valid_i) begin
          bus_valid_d = 1'b1;
          bus_addr_d  = cmd_addr_i;
          bus_rw_d    = cmd_rw_i;
          bus_data_d  = (cmd_rw_i == BUS_WRITE) ? cmd_data_i : '0;
          cmd_ready_d = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        stray_d = bus_valid_i && !match;
        // A return arriving in the timeout cycle still completes normally.
        if (match) begin
          resp_valid_d = 1'b1;
          resp_data_d  = bus_data_i;
          resp_err_d   = 1'b0;
          state_d      = StResp;
        end else if (timeout) begin
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        stray_d = bus_valid_i;
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          cmd_ready_d  = 1'b1;
          txn_count_d  = txn_count_q + COUNT_WIDTH'(1);
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_ready_q  <= 1'b1;
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
      bus_rw_q     <= 1'b0;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      stray_q      <= 1'b0;
      txn_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      bus_addr_q   <= bus_addr_d;
      bus_data_q   <= bus_data_d;
      bus_rw_q     <= bus_rw_d;
      bus_valid_q  <= bus_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      stray_q      <= stray_d;
      txn_count_q  <= txn_count_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_data_o   = bus_data_q;
  assign bus_rw_o     = bus_rw_q;
  assign bus_valid_o  = bus_valid_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign stray_o      = stray_q;
  assign txn_count_o  = txn_count_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: loopback, 3-stage memory chain, manual returns.
module tb_bus_initiator;
  import bus_pkg::*;

  localparam int ModeLoop   = 0;
  localparam int ModeChain  = 1;
  localparam int ModeManual = 2;

  logic        clk, rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_rw_i;
  logic [15:0] cmd_addr_i, cmd_data_i;
  logic [15:0] bus_addr_o, bus_data_o, bus_addr_i, bus_data_i;
  logic        bus_rw_o, bus_valid_o, bus_rw_i, bus_valid_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o, stray_o;
  logic [15:0] resp_data_o;
  logic [15:0] txn_count_o;

  int          mode;
  logic        man_valid, man_rw;
  logic [15:0] man_addr, man_data;

  // 3-stage chain whose first stage is a small memory core
  logic        c_v  [3];
  logic        c_rw [3];
  logic [15:0] c_a  [3];
  logic [15:0] c_d  [3];
  logic [15:0] mem  [256];

  int n_vec, n_err, exp_cnt;

  bus_initiator #(
    .TIMEOUT_CYCLES(8),
    .COUNT_WIDTH   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_rw_i    (cmd_rw_i),
    .bus_addr_o  (bus_addr_o),
    .bus_data_o  (bus_data_o),
    .bus_rw_o    (bus_rw_o),
    .bus_valid_o (bus_valid_o),
    .bus_addr_i  (bus_addr_i),
    .bus_data_i  (bus_data_i),
    .bus_rw_i    (bus_rw_i),
    .bus_valid_i (bus_valid_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_data_o (resp_data_o),
    .resp_err_o  (resp_err_o),
    .stray_o     (stray_o),
    .txn_count_o (txn_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) c_v[i] <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else begin
      c_v[0]  <= bus_valid_o;
      c_a[0]  <= bus_addr_o;
      c_rw[0] <= bus_rw_o;
      c_d[0]  <= bus_rw_o ? bus_data_o : mem[bus_addr_o[7:0]];
      if (bus_valid_o && bus_rw_o) mem[bus_addr_o[7:0]] <= bus_data_o;
      for (int i = 1; i < 3; i++) begin
        c_v[i]  <= c_v[i-1];
        c_a[i]  <= c_a[i-1];
        c_rw[i] <= c_rw[i-1];
        c_d[i]  <= c_d[i-1];
      end
    end
  end

  always_comb begin
    bus_valid_i = man_valid;
    bus_addr_i  = man_addr;
    bus_data_i  = man_data;
    bus_rw_i    = man_rw;
    if (mode == ModeLoop) begin
      bus_valid_i = bus_valid_o;
      bus_addr_i  = bus_addr_o;
      bus_data_i  = bus_data_o;
      bus_rw_i    = bus_rw_o;
    end else if (mode == ModeChain) begin
      bus_valid_i = c_v[2];
      bus_addr_i  = c_a[2];
      bus_data_i  = c_d[2];
      bus_rw_i    = c_rw[2];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one command; leaves the bench at the first WAIT-cycle negedge.
  task automatic issue(input logic rw, input logic [15:0] addr, input logic [15:0] data);
    int k;
    k = 0;
    while (!cmd_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready before issue", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_rw_i    = rw;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("bus_valid_o at issue", 32'(bus_valid_o), 32'd1);
    check("bus_addr_o at issue", 32'(bus_addr_o), 32'(addr));
    check("bus_data_o at issue", 32'(bus_data_o), rw ? 32'(data) : 32'd0);
    check("cmd_ready_o in WAIT", 32'(cmd_ready_o), 32'd0);
  endtask

  task automatic wait_resp(output int n, output int bv);
    n  = 0;
    bv = 0;
    while (!resp_valid_o && n < 100) begin
      bv += int'(bus_valid_o);
      @(negedge clk);
      n++;
    end
    bv += int'(bus_valid_o);
    check("response arrives within bound", 32'(resp_valid_o), 32'd1);
  endtask

  task automatic handshake();
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    exp_cnt++;
    check("resp_valid_o after handshake", 32'(resp_valid_o), 32'd0);
    check("cmd_ready_o after handshake", 32'(cmd_ready_o), 32'd1);
    check("txn_count_o", 32'(txn_count_o), 32'(exp_cnt));
  endtask

  typedef struct {
    int          mode;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_data;
    int          exp_wait;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, bv;
    logic [15:0] held;
    n_vec = 0; n_err = 0; exp_cnt = 0;
    mode = ModeLoop;
    man_valid = 1'b0; man_rw = 1'b0; man_addr = '0; man_data = '0;
    cmd_valid_i = 1'b0; cmd_rw_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0;
    resp_ready_i = 1'b0;

    vecs[0] = '{ModeLoop,  BUS_READ,  16'h0010, 16'hAAAA, 16'h0000, 1};
    vecs[1] = '{ModeLoop,  BUS_WRITE, 16'h0011, 16'h1357, 16'h1357, 1};
    vecs[2] = '{ModeChain, BUS_WRITE, 16'h0004, 16'hBEEF, 16'hBEEF, 4};
    vecs[3] = '{ModeChain, BUS_READ,  16'h0004, 16'h0000, 16'hBEEF, 4};
    vecs[4] = '{ModeChain, BUS_WRITE, 16'h00FF, 16'hFFFF, 16'hFFFF, 4};
    vecs[5] = '{ModeChain, BUS_READ,  16'h00FF, 16'h1111, 16'hFFFF, 4};
    vecs[6] = '{ModeChain, BUS_READ,  16'h0020, 16'h0000, 16'h0000, 4};
    vecs[7] = '{ModeChain, BUS_WRITE, 16'h0004, 16'h0001, 16'h0001, 4};
    vecs[8] = '{ModeChain, BUS_READ,  16'h0004, 16'h0000, 16'h0001, 4};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset cmd_ready_o", 32'(cmd_ready_o), 32'd1);
    check("reset bus_valid_o", 32'(bus_valid_o), 32'd0);
    check("reset resp_valid_o", 32'(resp_valid_o), 32'd0);
    check("reset stray_o", 32'(stray_o), 32'd0);
    check("reset txn_count_o", 32'(txn_count_o), 32'd0);
    check("reset bus_addr_o", 32'(bus_addr_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of complete transactions
    for (int i = 0; i < 9; i++) begin
      mode = vecs[i].mode;
      issue(vecs[i].rw, vecs[i].addr, vecs[i].data);
      wait_resp(n, bv);
      check($sformatf("vec%0d wait cycles", i), 32'(n), 32'(vecs[i].exp_wait));
      check($sformatf("vec%0d bus_valid cycles", i), 32'(bv), 32'd1);
      check($sformatf("vec%0d resp_data_o", i), 32'(resp_data_o), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d resp_err_o", i), 32'(resp_err_o), 32'd0);
      check($sformatf("vec%0d stray_o", i), 32'(stray_o), 32'd0);
      handshake();
      check($sformatf("vec%0d bus_addr_o held", i), 32'(bus_addr_o), 32'(vecs[i].addr));
    end

    // Response back-pressure: held response, no command accepted meanwhile
    mode = ModeLoop;
    issue(BUS_WRITE, 16'h0022, 16'h5A5A);
    wait_resp(n, bv);
    held = resp_data_o;
    check("backpressure resp_data_o", 32'(held), 32'h5A5A);
    for (int c = 0; c < 10; c++) begin
      cmd_valid_i = (c == 4);
      cmd_addr_i  = 16'h0099;
      cmd_rw_i    = BUS_READ;
      @(negedge clk);
      check("held resp_valid_o", 32'(resp_valid_o), 32'd1);
      check("held resp_data_o", 32'(resp_data_o), 32'(held));
      check("held cmd_ready_o", 32'(cmd_ready_o), 32'd0);
      check("held bus_valid_o", 32'(bus_valid_o), 32'd0);
    end
    cmd_valid_i = 1'b0;
    check("held bus_addr_o", 32'(bus_addr_o), 32'h0022);
    handshake();
    @(negedge clk);
    check("no issue after handshake", 32'(bus_valid_o), 32'd0);

    // Stray returns while WAIT for 0x0004, then the proper return
    mode = ModeManual;
    issue(BUS_READ, 16'h0004, 16'h0000);
    man_valid = 1'b1; man_addr = 16'h0005; man_rw = BUS_READ; man_data = 16'hDEAD;
    @(negedge clk);
    man_valid = 1'b0;
    check("wrong addr stray_o", 32'(stray_o), 32'd1);
    check("wrong addr resp_valid_o", 32'(resp_valid_o), 32'd0);
    @(negedge clk);
    check("stray_o one cycle", 32'(stray_o), 32'd0);
    man_valid = 1'b1; man_addr = 16'h0004; man_rw = BUS_WRITE;
    @(negedge clk);
    man_valid = 1'b0;
    check("wrong rw stray_o", 32'(stray_o), 32'd1);
    check("wrong rw resp_valid_o", 32'(resp_valid_o), 32'd0);
    man_valid = 1'b1; man_addr = 16'h0004; man_rw = BUS_READ; man_data = 16'h7777;
    @(negedge clk);
    man_valid = 1'b0;
    check("match resp_valid_o", 32'(resp_valid_o), 32'd1);
    check("match resp_data_o", 32'(resp_data_o), 32'h7777);
    check("match stray_o", 32'(stray_o), 32'd0);
    handshake();
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    check("idle stray_o", 32'(stray_o), 32'd1);
    check("idle resp_valid_o", 32'(resp_valid_o), 32'd0);

`ifdef BUS_INITIATOR_TIMEOUT_EN
    // Timeout after 8 WAIT cycles, late return is stray
    issue(BUS_READ, 16'h0030, 16'h0000);
    wait_resp(n, bv);
    check("timeout wait cycles", 32'(n), 32'd8);
    check("timeout resp_err_o", 32'(resp_err_o), 32'd1);
    check("timeout resp_data_o", 32'(resp_data_o), 32'd0);
    handshake();
    man_valid = 1'b1; man_addr = 16'h0030; man_rw = BUS_READ; man_data = 16'h3333;
    @(negedge clk);
    man_valid = 1'b0;
    check("late return stray_o", 32'(stray_o), 32'd1);
    // Return in the timeout cycle wins over the timeout
    issue(BUS_READ, 16'h0031, 16'h0000);
    repeat (7) @(negedge clk);
    check("no early timeout", 32'(resp_valid_o), 32'd0);
    man_valid = 1'b1; man_addr = 16'h0031; man_rw = BUS_READ; man_data = 16'h4242;
    @(negedge clk);
    man_valid = 1'b0;
    check("tie resp_valid_o", 32'(resp_valid_o), 32'd1);
    check("tie resp_err_o", 32'(resp_err_o), 32'd0);
    check("tie resp_data_o", 32'(resp_data_o), 32'h4242);
    handshake();
`endif

    // Reset during WAIT abandons the transaction
    issue(BUS_WRITE, 16'h0040, 16'h1111);
    rst = 1'b1;
    #1;
    check("async reset bus_valid_o", 32'(bus_valid_o), 32'd0);
    check("async reset cmd_ready_o", 32'(cmd_ready_o), 32'd1);
    check("async reset txn_count_o", 32'(txn_count_o), 32'd0);
    check("async reset bus_addr_o", 32'(bus_addr_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    man_valid = 1'b1; man_addr = 16'h0040; man_rw = BUS_WRITE; man_data = 16'h1111;
    @(negedge clk);
    man_valid = 1'b0;
    check("post-reset return stray_o", 32'(stray_o), 32'd1);
    check("post-reset resp_valid_o", 32'(resp_valid_o), 32'd0);
    repeat (3) @(negedge clk);
    check("no response after reset", 32'(resp_valid_o), 32'd0);
    check("cmd_ready_o after reset", 32'(cmd_ready_o), 32'd1);
    check("txn_count_o after reset", 32'(txn_count_o), 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
Host-side master for the 16-bit addr/data/rw/valid daisy-chain bus used by the memory and register cores.
- Accepts one command at a time on a valid/ready command port.
- Launches it as a single-cycle bus transaction at the head of the chain.
- Matches the transaction when it returns from the tail of the chain, then presents the result on a valid/ready response port.
- Sits between the host-link decoder and the first core in the chain.

Parameters:
TIMEOUT_CYCLES, 1024, WAIT-state cycles before abandoning a transaction (used only with the timeout feature); must be >= 1.
COUNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  reset, asynchronous, active-high.
cmd_valid_i  in  1  command present.
cmd_ready_o  out  1  block can accept a command.
cmd_addr_i  in  16  bus address.
cmd_data_i  in  16  write data; ignored for reads.
cmd_rw_i  in  1  1 = write, 0 = read.
bus_addr_o  out  16  chain head address.
bus_data_o  out  16  chain head data.
bus_rw_o  out  1  chain head rw.
bus_valid_o  out  1  chain head valid.
bus_addr_i  in  16  chain tail address.
bus_data_i  in  16  chain tail data.
bus_rw_i  in  1  chain tail rw.
bus_valid_i  in  1  chain tail valid.
resp_valid_o  out  1  response present.
resp_ready_i  in  1  consumer accepts the response.
resp_data_o  out  16  returned data; read data, or echoed data for writes.
resp_err_o  out  1  transaction timed out.
stray_o  out  1  one-cycle pulse: unmatched bus_valid_i seen.
txn_count_o  out  COUNT_WIDTH  completed responses, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0, except cmd_ready_o = 1; latched command cleared; counters cleared.
- Reset mid-transaction abandons the transaction. No response is produced. A late return after reset counts as stray.
- States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - cmd_ready_o = 1.
  - When cmd_valid_i is high, latch addr/data/rw; next cycle bus_*_o carry the latched values, bus_valid_o = 1, state WAIT, cmd_ready_o = 0.
- bus_valid_o is high for exactly one cycle per command.
  - bus_addr_o, bus_data_o and bus_rw_o hold their values until the next issue.
  - For reads, bus_data_o = 0.
- WAIT:
  - Match when bus_valid_i = 1 and bus_addr_i equals the latched addr and bus_rw_i equals the latched rw.
  - A match is honoured even in the same cycle that bus_valid_o is high, which supports zero-core loopback.
  - On match: resp_data_o <= bus_data_i, resp_err_o <= 0, state RESP, resp_valid_o = 1 next cycle.
  - bus_valid_i without a match pulses stray_o; state unchanged.
- RESP:
  - resp_valid_o and resp_data_o held stable until resp_ready_i = 1.
  - On the handshake: txn_count_o increments, resp_valid_o drops next cycle, state IDLE, cmd_ready_o = 1 next cycle.
  - No command is accepted in the handshake cycle itself.
- In IDLE or RESP, any bus_valid_i pulses stray_o one cycle later.
- Maximum throughput: one transaction per (chain latency + 3) cycles.

Optional Feature:
Macro BUS_INITIATOR_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no match: state RESP, resp_err_o = 1, resp_data_o = 16'h0000.
  - A match in the same cycle as the timeout wins.
  - A late return after a timeout is stray.
- Undefined: WAIT lasts indefinitely; resp_err_o is tied to 0; no counter logic.

Decomposition:
- Package bus_pkg holds:
  - BUS_ADDR_W = 16 and BUS_DATA_W = 16.
  - BUS_READ = 1'b0 and BUS_WRITE = 1'b1.
  - The initiator state enum typedef (IDLE, WAIT, RESP).
- One natural sub-module: bus_timeout_counter, a clear/enable/terminal-count counter instantiated only under BUS_INITIATOR_TIMEOUT_EN.

Test Plan:
1. Loopback (bus_*_i tied to bus_*_o), read addr 16'h0010 -> bus_valid_o high 1 cycle; resp_data_o = 16'h0000; resp_err_o = 0; txn_count_o = 1.
2. 3-stage delay chain modelling a memory core: write 16'hBEEF to 16'h0004, then read 16'h0004 -> second response resp_data_o = 16'hBEEF; txn_count_o = 2.
3. resp_ready_i held low 10 cycles -> resp_valid_o and resp_data_o stable; cmd_ready_o = 0; a cmd_valid_i pulse in that window is not accepted.
4. In WAIT, inject bus_valid_i with addr 16'h0005 while 16'h0004 is pending -> stray_o pulses once; correct return completes normally.
5. BUS_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES = 8, no return -> resp_valid_o after 8 WAIT cycles; resp_err_o = 1; resp_data_o = 0. A late return then pulses stray_o.
6. Assert rst during WAIT -> outputs reset immediately; cmd_ready_o = 1 after release; no response; txn_count_o = 0.
